// File: rtl/dot_product_engine.sv
// Streams packed operand words from two input SRAMs, sums the lane-wise products
// over a programmable number of words, and writes the result to the output SRAM.
`timescale 1ns/1ps
module dot_product_engine #(
  parameter int Data_Width = 8,
  parameter int Addr_Width = 4,
  parameter int Ram_Depth  = 1 << Addr_Width,
  parameter int Para_Deg   = 4,
  parameter int Acc_Width  = 2*Data_Width + Addr_Width + $clog2(Para_Deg)
) (
  input  logic                           clk,
  input  logic                           Rst_n,
  input  logic                           Start,
  input  logic [Addr_Width:0]            Length,
  input  logic [Addr_Width-1:0]          Out_Addr,
  output logic                           Busy,
  output logic                           Done,
  output logic                           In0_Chip_Select,
  output logic                           In1_Chip_Select,
  output logic                           In0_En_Read,
  output logic                           In1_En_Read,
  output logic [Addr_Width-1:0]          In0_Read_Addr,
  output logic [Addr_Width-1:0]          In1_Read_Addr,
  input  logic [Para_Deg*Data_Width-1:0] In0_Read_Data,
  input  logic [Para_Deg*Data_Width-1:0] In1_Read_Data,
  output logic                           Out_Chip_Select,
  output logic                           Out_En_Write,
  output logic [Addr_Width-1:0]          Out_Write_Addr,
  output logic [Para_Deg*Data_Width-1:0] Out_Write_Data
);

  localparam int Word_Width = Para_Deg * Data_Width;
  localparam int Len_Width  = Addr_Width + 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [Len_Width-1:0]    len_reg, len_next;
  logic [Len_Width-1:0]    idx_reg, idx_next;
  logic [Addr_Width-1:0]   out_addr_reg, out_addr_next;
  logic [Acc_Width-1:0]    acc_reg, acc_next;
  logic                    valid_reg, valid_next;

  logic [2*Data_Width-1:0] lane_prod [Para_Deg];
  logic [Acc_Width-1:0]    word_sum;
  logic [Len_Width-1:0]    length_clamped;

  genvar gi;
  generate
    for (gi = 0; gi < Para_Deg; gi++) begin : g_lane
      assign lane_prod[gi] =
        {{Data_Width{1'b0}}, In0_Read_Data[gi*Data_Width +: Data_Width]} *
        {{Data_Width{1'b0}}, In1_Read_Data[gi*Data_Width +: Data_Width]};
    end
  endgenerate

  always_comb begin
    word_sum = '0;
    for (int k = 0; k < Para_Deg; k++) begin
      word_sum = word_sum + Acc_Width'(lane_prod[k]);
    end
  end

  assign length_clamped = (Length > Len_Width'(Ram_Depth)) ? Len_Width'(Ram_Depth) : Length;

  always_comb begin
    state_next      = state_reg;
    len_next        = len_reg;
    idx_next        = idx_reg;
    out_addr_next   = out_addr_reg;
    acc_next        = acc_reg;
    valid_next      = 1'b0;
    Busy            = (state_reg != S_IDLE);
    Done            = 1'b0;
    In0_Chip_Select = 1'b0;
    In1_Chip_Select = 1'b0;
    In0_En_Read     = 1'b0;
    In1_En_Read     = 1'b0;
    In0_Read_Addr   = '0;
    In1_Read_Addr   = '0;
    Out_Chip_Select = 1'b0;
    Out_En_Write    = 1'b0;
    Out_Write_Addr  = '0;
    Out_Write_Data  = '0;

    // Read data arrives one cycle after its address; fold it in that cycle.
    if (valid_reg) begin
      acc_next = acc_reg + word_sum;
    end

    case (state_reg)
      S_IDLE: begin
        if (Start) begin
          len_next      = length_clamped;
          out_addr_next = Out_Addr;
          acc_next      = '0;
          idx_next      = '0;
          state_next    = (length_clamped == '0) ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        In0_Chip_Select = 1'b1;
        In1_Chip_Select = 1'b1;
        In0_En_Read     = 1'b1;
        In1_En_Read     = 1'b1;
        In0_Read_Addr   = idx_reg[Addr_Width-1:0];
        In1_Read_Addr   = idx_reg[Addr_Width-1:0];
        valid_next      = 1'b1;
        idx_next        = idx_reg + Len_Width'(1);
        if (idx_reg == len_reg - Len_Width'(1)) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_next = S_WRITE;
      end
      S_WRITE: begin
        Out_Chip_Select = 1'b1;
        Out_En_Write    = 1'b1;
        Out_Write_Addr  = out_addr_reg;
        Out_Write_Data  = Word_Width'(acc_reg);
        state_next      = S_DONE;
      end
      S_DONE: begin
        Done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      idx_reg      <= '0;
      out_addr_reg <= '0;
      acc_reg      <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      idx_reg      <= idx_next;
      out_addr_reg <= out_addr_next;
      acc_reg      <= acc_next;
      valid_reg    <= valid_next;
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed table of dot-product runs checked cycle by cycle against hand-computed
// results, plus a mid-run reset sequence.
`timescale 1ns/1ps
module tb_dot_product_engine;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [4:0]  Length;
  logic [3:0]  Out_Addr;
  logic        Busy, Done;
  logic        In0_Chip_Select, In1_Chip_Select, In0_En_Read, In1_En_Read;
  logic [3:0]  In0_Read_Addr, In1_Read_Addr;
  logic [31:0] In0_Read_Data, In1_Read_Data;
  logic        Out_Chip_Select, Out_En_Write;
  logic [3:0]  Out_Write_Addr;
  logic [31:0] Out_Write_Data;

  always #5 clk = ~clk;

  dot_product_engine dut (
    .clk             (clk),
    .Rst_n           (Rst_n),
    .Start           (Start),
    .Length          (Length),
    .Out_Addr        (Out_Addr),
    .Busy            (Busy),
    .Done            (Done),
    .In0_Chip_Select (In0_Chip_Select),
    .In1_Chip_Select (In1_Chip_Select),
    .In0_En_Read     (In0_En_Read),
    .In1_En_Read     (In1_En_Read),
    .In0_Read_Addr   (In0_Read_Addr),
    .In1_Read_Addr   (In1_Read_Addr),
    .In0_Read_Data   (In0_Read_Data),
    .In1_Read_Data   (In1_Read_Data),
    .Out_Chip_Select (Out_Chip_Select),
    .Out_En_Write    (Out_En_Write),
    .Out_Write_Addr  (Out_Write_Addr),
    .Out_Write_Data  (Out_Write_Data)
  );

  // Input SRAM models with registered read, and a write counter on the output port.
  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  int          wr_count = 0;

  always @(posedge clk) begin
    if (In0_Chip_Select && In0_En_Read) In0_Read_Data <= mem0[In0_Read_Addr];
    if (In1_Chip_Select && In1_En_Read) In1_Read_Data <= mem1[In1_Read_Addr];
    if (Out_Chip_Select && Out_En_Write) wr_count <= wr_count + 1;
  end

  logic [51:0] obs;
  assign obs = {In0_Chip_Select, In0_En_Read, In0_Read_Addr,
                In1_Chip_Select, In1_En_Read, In1_Read_Addr,
                Out_Chip_Select, Out_En_Write, Out_Write_Addr, Out_Write_Data,
                Done, Busy};

  typedef struct {
    logic [4:0]  len;
    logic [3:0]  out_addr;
    int          kind;
    int          reads;
    logic [31:0] result;
    int          wcycle;
    bit          repulse;
  } vec_t;

  vec_t vecs [7];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [51:0] got, input logic [51:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0: begin
          mem0[i] = (i == 0) ? {8'd4, 8'd3, 8'd2, 8'd1} : {4{8'hEE}};
          mem1[i] = (i == 0) ? {8'd8, 8'd7, 8'd6, 8'd5} : {4{8'hEE}};
        end
        1: begin
          mem0[i] = {4{8'(i + 1)}};
          mem1[i] = {4{8'(i + 1)}};
        end
        default: begin
          mem0[i] = {4{8'hFF}};
          mem1[i] = {4{8'hFF}};
        end
      endcase
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic        rd, wr;
    logic [3:0]  a;
    logic [51:0] e;
    fill(v.kind);
    for (int c = 0; c <= v.wcycle + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        Start = 1'b1; Length = v.len; Out_Addr = v.out_addr;
      end else if (v.repulse && c == 2) begin
        Start = 1'b1; Length = 5'd1; Out_Addr = 4'd3;
      end else begin
        Start = 1'b0;
      end
      rd = (c >= 1) && (c <= v.reads);
      wr = (c == v.wcycle);
      a  = rd ? 4'(c - 1) : 4'd0;
      e  = {rd, rd, a, rd, rd, a, wr, wr, wr ? v.out_addr : 4'd0,
            wr ? v.result : 32'd0, (c == v.wcycle + 1), (c >= 1) && (c <= v.wcycle + 1)};
      check($sformatf("vec%0d cycle%0d", id, c), obs, e);
    end
  endtask

  initial begin
    int wr_before;
    vecs[0] = '{len: 5'd1,  out_addr: 4'd10, kind: 0, reads: 1,  result: 32'd70,      wcycle: 3,  repulse: 1'b0};
    vecs[1] = '{len: 5'd3,  out_addr: 4'd5,  kind: 1, reads: 3,  result: 32'd56,      wcycle: 5,  repulse: 1'b0};
    vecs[2] = '{len: 5'd16, out_addr: 4'd15, kind: 2, reads: 16, result: 32'd4161600, wcycle: 18, repulse: 1'b0};
    vecs[3] = '{len: 5'd0,  out_addr: 4'd7,  kind: 0, reads: 0,  result: 32'd0,       wcycle: 1,  repulse: 1'b0};
    vecs[4] = '{len: 5'd3,  out_addr: 4'd9,  kind: 1, reads: 3,  result: 32'd56,      wcycle: 5,  repulse: 1'b1};
    vecs[5] = '{len: 5'd20, out_addr: 4'd2,  kind: 2, reads: 16, result: 32'd4161600, wcycle: 18, repulse: 1'b0};
    vecs[6] = '{len: 5'd2,  out_addr: 4'd0,  kind: 1, reads: 2,  result: 32'd20,      wcycle: 4,  repulse: 1'b0};

    Rst_n = 1'b0; Start = 1'b0; Length = '0; Out_Addr = '0;
    In0_Read_Data = '0; In1_Read_Data = '0;
    fill(0);
    repeat (2) @(negedge clk);
    check("reset outputs", obs, 52'd0);
    Rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort a Length=3 run with reset while reads are in flight.
    fill(1);
    @(negedge clk); Start = 1'b1; Length = 5'd3; Out_Addr = 4'd6;
    @(negedge clk); Start = 1'b0;
    @(negedge clk);
    Rst_n = 1'b0;
    #1 check("async reset mid-read", obs, 52'd0);
    wr_before = wr_count;
    repeat (3) @(negedge clk);
    check("held in reset", obs, 52'd0);
    Rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no write after abort", 52'(wr_count), 52'(wr_before));
    check("idle after abort", obs, 52'd0);
    run_vec(7, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
